// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared constants and types for the data-cache port arbiter.
//   AW/DW/IDW     : address, data and id/tag widths
//   NUM_TAGS      : number of memory tags (2**IDW)
//   tag_t         : memory tag / requester id
//   tag_entry_t   : one tag-table slot {busy, owner, orig_id}
//   popcount()    : number of set bits in a busy vector
package mem_arb_pkg;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int IDW      = 4;
    localparam int NUM_TAGS = 2 ** IDW;

    typedef logic [IDW-1:0] tag_t;

    typedef struct packed {
        logic busy;
        logic owner;    // 0 = R0, 1 = R1
        tag_t orig_id;
    } tag_entry_t;

    function automatic logic [IDW:0] popcount(input logic [NUM_TAGS-1:0] v);
        logic [IDW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) cnt = cnt + (IDW+1)'(v[i]);
        return cnt;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles both requester ports, the memory port and the tag occupancy count.
//   slave  : arbiter side (takes requests and memory responses, drives grants/issue/responses)
//   master : environment side (requesters + memory model)
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic          r0_valid, r0_rw, r0_grant, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rsp_data;
    tag_t          r0_id, r0_rsp_id;

    logic          r1_valid, r1_rw, r1_grant, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rsp_data;
    tag_t          r1_id, r1_rsp_id;

    logic          m_valid, m_rw, m_stall, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    tag_t          m_tag, m_rtag;
    logic [IDW:0]  tags_busy;

    modport slave (
        input  r0_valid, r0_rw, r0_addr, r0_wdata, r0_id,
        output r0_grant, r0_rsp_valid, r0_rsp_data, r0_rsp_id,
        input  r1_valid, r1_rw, r1_addr, r1_wdata, r1_id,
        output r1_grant, r1_rsp_valid, r1_rsp_data, r1_rsp_id,
        output m_valid, m_rw, m_addr, m_wdata, m_tag, tags_busy,
        input  m_stall, m_ready, m_rdata, m_rtag
    );

    modport master (
        output r0_valid, r0_rw, r0_addr, r0_wdata, r0_id,
        input  r0_grant, r0_rsp_valid, r0_rsp_data, r0_rsp_id,
        output r1_valid, r1_rw, r1_addr, r1_wdata, r1_id,
        input  r1_grant, r1_rsp_valid, r1_rsp_data, r1_rsp_id,
        input  m_valid, m_rw, m_addr, m_wdata, m_tag, tags_busy,
        output m_stall, m_ready, m_rdata, m_rtag
    );
endinterface

// File: rtl/mem_arb_tag_table.sv
// mem_arb_tag_table
//   Tag table: per-tag {busy, owner, orig_id}, lowest-free-tag encoder, busy count.
//   clk, rst                         : clock, async active-low reset
//   i_alloc/i_alloc_owner/i_alloc_id : claim o_free_tag for a requester
//   o_free_avail/o_free_tag          : lowest free tag from registered state
//   i_free/i_free_tag                : release a busy tag
//   i_lookup_tag/o_lookup            : combinational read of one entry
//   o_busy_cnt                       : registered number of busy tags
module mem_arb_tag_table
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_alloc,
    input  logic         i_alloc_owner,
    input  tag_t         i_alloc_id,
    output logic         o_free_avail,
    output tag_t         o_free_tag,
    input  logic         i_free,
    input  tag_t         i_free_tag,
    input  tag_t         i_lookup_tag,
    output tag_entry_t   o_lookup,
    output logic [IDW:0] o_busy_cnt
);
    tag_entry_t          r_tab [NUM_TAGS];
    logic [IDW:0]        r_busy_cnt;
    logic [NUM_TAGS-1:0] w_busy_nxt;

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        o_free_avail = 1'b0;
        o_free_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_tab[i].busy) begin
                o_free_avail = 1'b1;
                o_free_tag   = tag_t'(i);
            end
        end
    end

    // Alloc and free never target the same tag (one is free, the other busy).
    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++) w_busy_nxt[i] = r_tab[i].busy;
        if (i_alloc) w_busy_nxt[o_free_tag] = 1'b1;
        if (i_free)  w_busy_nxt[i_free_tag] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) r_tab[i] <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (i_alloc) r_tab[o_free_tag] <= '{busy: 1'b1, owner: i_alloc_owner, orig_id: i_alloc_id};
            if (i_free)  r_tab[i_free_tag].busy <= 1'b0;
            r_busy_cnt <= popcount(w_busy_nxt);
        end
    end

    assign o_lookup   = r_tab[i_lookup_tag];
    assign o_busy_cnt = r_busy_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the data-cache request port between R0 (ld/st queue) and R1 (fetch-miss/debug).
//   Requests get the lowest free memory tag; responses are routed back by tag with the
//   requester's original id.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : mem_port_arbiter_if.slave (requester ports, memory port, tags_busy)
//   Build option MEM_ARB_R0_PRIO_EN: fixed priority to R0 instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    logic        w_can, w_sel1, w_gnt0, w_gnt1, w_gnt_any;
    logic        w_free_avail, w_rsp_hit;
    tag_t        w_free_tag;
    tag_entry_t  w_entry;

    logic                   r_m_valid, r_m_rw;
    logic [AW-1:0]          r_m_addr;
    logic [DW-1:0]          r_m_wdata;
    tag_t                   r_m_tag;
    logic [1:0]             r_rsp_valid;
    logic [1:0][DW-1:0]     r_rsp_data;
    logic [1:0][IDW-1:0]    r_rsp_id;

    assign w_can = !bus.m_stall && w_free_avail;

`ifdef MEM_ARB_R0_PRIO_EN
    assign w_sel1 = bus.r1_valid && !bus.r0_valid;
`else
    logic r_ptr;    // 1 = R1 favoured on contention

    assign w_sel1 = bus.r1_valid && (!bus.r0_valid || r_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_ptr <= 1'b0;
        else if (w_gnt_any) r_ptr <= w_gnt0;    // favour whoever just lost
    end
`endif

    assign w_gnt0    = w_can && bus.r0_valid && !w_sel1;
    assign w_gnt1    = w_can && w_sel1;
    assign w_gnt_any = w_gnt0 || w_gnt1;

    // Stray responses on a free tag (including ones crossing a reset) fall out here.
    assign w_rsp_hit = bus.m_ready && w_entry.busy;

    mem_arb_tag_table u_tag_table (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (w_gnt_any),
        .i_alloc_owner (w_gnt1),
        .i_alloc_id    (w_gnt1 ? bus.r1_id : bus.r0_id),
        .o_free_avail  (w_free_avail),
        .o_free_tag    (w_free_tag),
        .i_free        (w_rsp_hit),
        .i_free_tag    (bus.m_rtag),
        .i_lookup_tag  (bus.m_rtag),
        .o_lookup      (w_entry),
        .o_busy_cnt    (bus.tags_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid   <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_tag     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_m_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_m_rw    <= w_gnt1 ? bus.r1_rw    : bus.r0_rw;
                r_m_addr  <= w_gnt1 ? bus.r1_addr  : bus.r0_addr;
                r_m_wdata <= w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
                r_m_tag   <= w_free_tag;
            end
            r_rsp_valid <= '0;
            if (w_rsp_hit) begin
                r_rsp_valid[w_entry.owner] <= 1'b1;
                r_rsp_data[w_entry.owner]  <= bus.m_rdata;
                r_rsp_id[w_entry.owner]    <= w_entry.orig_id;
            end
        end
    end

    assign bus.r0_grant     = w_gnt0;
    assign bus.r1_grant     = w_gnt1;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_rw         = r_m_rw;
    assign bus.m_addr       = r_m_addr;
    assign bus.m_wdata      = r_m_wdata;
    assign bus.m_tag        = r_m_tag;
    assign bus.r0_rsp_valid = r_rsp_valid[0];
    assign bus.r0_rsp_data  = r_rsp_data[0];
    assign bus.r0_rsp_id    = r_rsp_id[0];
    assign bus.r1_rsp_valid = r_rsp_valid[1];
    assign bus.r1_rsp_data  = r_rsp_data[1];
    assign bus.r1_rsp_id    = r_rsp_id[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Stimulus pushes expected memory requests and
//   responses into queues; a negedge monitor pops and compares whenever the DUT shows
//   m_valid / r0_rsp_valid / r1_rsp_valid.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        tag_t          tag;
    } mreq_t;

    typedef struct {
        logic [DW-1:0] data;
        tag_t          id;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mreq_t mq[$];
    rsp_t  r0q[$];
    rsp_t  r1q[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus.m_valid) begin
                if (mq.size() == 0) chk("m_valid_unexpected", 64'(bus.m_valid), 64'd0);
                else begin
                    mreq_t e;
                    e = mq.pop_front();
                    chk("m_rw",    64'(bus.m_rw),    64'(e.rw));
                    chk("m_addr",  64'(bus.m_addr),  64'(e.addr));
                    chk("m_wdata", 64'(bus.m_wdata), 64'(e.wdata));
                    chk("m_tag",   64'(bus.m_tag),   64'(e.tag));
                end
            end
            if (bus.r0_rsp_valid) begin
                if (r0q.size() == 0) chk("r0_rsp_unexpected", 64'(bus.r0_rsp_valid), 64'd0);
                else begin
                    rsp_t e;
                    e = r0q.pop_front();
                    chk("r0_rsp_data", 64'(bus.r0_rsp_data), 64'(e.data));
                    chk("r0_rsp_id",   64'(bus.r0_rsp_id),   64'(e.id));
                end
            end
            if (bus.r1_rsp_valid) begin
                if (r1q.size() == 0) chk("r1_rsp_unexpected", 64'(bus.r1_rsp_valid), 64'd0);
                else begin
                    rsp_t e;
                    e = r1q.pop_front();
                    chk("r1_rsp_data", 64'(bus.r1_rsp_data), 64'(e.data));
                    chk("r1_rsp_id",   64'(bus.r1_rsp_id),   64'(e.id));
                end
            end
        end
    end

    task automatic clr_inputs();
        bus.r0_valid = 0; bus.r0_rw = 0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_id = '0;
        bus.r1_valid = 0; bus.r1_rw = 0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_id = '0;
        bus.m_stall = 0; bus.m_ready = 0; bus.m_rdata = '0; bus.m_rtag = '0;
    endtask

    task automatic drv0(input logic v, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input tag_t id);
        bus.r0_valid = v; bus.r0_rw = rw; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_id = id;
    endtask

    task automatic drv1(input logic v, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input tag_t id);
        bus.r1_valid = v; bus.r1_rw = rw; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_id = id;
    endtask

    task automatic mrsp(input logic v, input tag_t t, input logic [DW-1:0] d);
        bus.m_ready = v; bus.m_rtag = t; bus.m_rdata = d;
    endtask

    task automatic exp_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input tag_t t);
        mreq_t e;
        e.rw = rw; e.addr = a; e.wdata = d; e.tag = t;
        mq.push_back(e);
    endtask

    task automatic exp_rsp(input int r, input logic [DW-1:0] d, input tag_t id);
        rsp_t e;
        e.data = d; e.id = id;
        if (r == 0) r0q.push_back(e);
        else        r1q.push_back(e);
    endtask

    // One cycle: check grants and occupancy mid-cycle, then advance past the edge.
    task automatic step(input string nm, input logic g0, input logic g1, input int busy);
        @(negedge clk);
        chk({nm, "_r0_grant"},  64'(bus.r0_grant),  64'(g0));
        chk({nm, "_r1_grant"},  64'(bus.r1_grant),  64'(g1));
        chk({nm, "_tags_busy"}, 64'(bus.tags_busy), 64'(busy));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0;
        clr_inputs();
        @(negedge clk);
        chk("rst_m_valid",      64'(bus.m_valid),      64'd0);
        chk("rst_m_tag",        64'(bus.m_tag),        64'd0);
        chk("rst_m_addr",       64'(bus.m_addr),       64'd0);
        chk("rst_r0_rsp_valid", 64'(bus.r0_rsp_valid), 64'd0);
        chk("rst_r1_rsp_valid", 64'(bus.r1_rsp_valid), 64'd0);
        chk("rst_r0_rsp_data",  64'(bus.r0_rsp_data),  64'd0);
        chk("rst_tags_busy",    64'(bus.tags_busy),    64'd0);
        rst = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic g1;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;

        // 1: reset, idle
        do_reset();
        repeat (3) step("t1_idle", 0, 0, 0);

        // 2: single R0 load round trip
        drv0(1, 0, 32'h40, 32'h0, 4'd5);
        exp_req(0, 32'h40, 32'h0, 4'd0);
        step("t2_issue", 1, 0, 0);
        drv0(0, 0, '0, '0, '0);
        step("t2_wait", 0, 0, 1);
        mrsp(1, 4'd0, 32'hDEAD);
        exp_rsp(0, 32'hDEAD, 4'd5);
        step("t2_rsp", 0, 0, 1);
        mrsp(0, '0, '0);
        step("t2_done", 0, 0, 0);

        // 3: contention for four cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv0(1, 0, 32'h100 + 32'(i), 32'h0, 4'd1);
            drv1(1, 1, 32'h200 + 32'(i), 32'hA0 + 32'(i), 4'd2);
`ifdef MEM_ARB_R0_PRIO_EN
            g1 = 1'b0;
`else
            g1 = (i % 2) == 1;
`endif
            if (g1) exp_req(1, 32'h200 + 32'(i), 32'hA0 + 32'(i), tag_t'(i));
            else    exp_req(0, 32'h100 + 32'(i), 32'h0, tag_t'(i));
            step("t3_arb", !g1, g1, i);
        end
        drv0(0, 0, '0, '0, '0);
        drv1(0, 0, '0, '0, '0);
        step("t3_busy", 0, 0, 4);

        // 4: exhaust all tags, then free tag 7
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drv0(1, i[0], 32'(i * 4), 32'(i), tag_t'(i));
            exp_req(i[0], 32'(i * 4), 32'(i), tag_t'(i));
            step("t4_fill", 1, 0, i);
        end
        drv0(1, 0, 32'h999, 32'h0, 4'hA);
        mrsp(1, 4'd7, 32'h77);
        exp_rsp(0, 32'h77, 4'd7);
        step("t4_full", 0, 0, 16);
        mrsp(0, '0, '0);
        exp_req(0, 32'h999, 32'h0, 4'd7);
        step("t4_reuse", 1, 0, 15);
        drv0(0, 0, '0, '0, '0);
        step("t4_full2", 0, 0, 16);
        // reset with all tags in flight; late response must be dropped
        do_reset();
        mrsp(1, 4'd3, 32'h33);
        step("t4_late", 0, 0, 0);
        mrsp(0, '0, '0);
        step("t4_after", 0, 0, 0);

        // 5: stall blocks grants, issued request is not retracted
        do_reset();
        bus.m_stall = 1;
        drv0(1, 0, 32'h500, 32'h0, 4'd1);
        drv1(1, 1, 32'h600, 32'h66, 4'd2);
        step("t5_stall", 0, 0, 0);
        step("t5_stall", 0, 0, 0);
        bus.m_stall = 0;
        exp_req(0, 32'h500, 32'h0, 4'd0);
        step("t5_release", 1, 0, 0);
        drv0(0, 0, '0, '0, '0);
        bus.m_stall = 1;
        step("t5_restall", 0, 0, 1);
        bus.m_stall = 0;
        exp_req(1, 32'h600, 32'h66, 4'd1);
        step("t5_r1", 0, 1, 1);
        drv1(0, 0, '0, '0, '0);
        step("t5_done", 0, 0, 2);

        // 6: out-of-order responses, grant+response same cycle, stray tag
        do_reset();
        drv0(1, 0, 32'h10, 32'h0, 4'd3);
        exp_req(0, 32'h10, 32'h0, 4'd0);
        step("t6_r0", 1, 0, 0);
        drv0(0, 0, '0, '0, '0);
        drv1(1, 0, 32'h20, 32'h0, 4'd9);
        exp_req(0, 32'h20, 32'h0, 4'd1);
        step("t6_r1", 0, 1, 1);
        drv1(0, 0, '0, '0, '0);
        mrsp(1, 4'd1, 32'h1111);
        exp_rsp(1, 32'h1111, 4'd9);
        step("t6_rsp1", 0, 0, 2);
        mrsp(1, 4'd0, 32'h2222);
        exp_rsp(0, 32'h2222, 4'd3);
        drv1(1, 1, 32'h30, 32'h44, 4'd4);
        exp_req(1, 32'h30, 32'h44, 4'd1);
        step("t6_both", 0, 1, 1);
        drv1(0, 0, '0, '0, '0);
        mrsp(1, 4'd12, 32'hBAD);
        step("t6_stray", 0, 0, 1);
        mrsp(1, 4'd1, 32'h3333);
        exp_rsp(1, 32'h3333, 4'd4);
        step("t6_st_rsp", 0, 0, 1);
        mrsp(0, '0, '0);
        step("t6_drain", 0, 0, 0);
        step("t6_idle", 0, 0, 0);

        chk("mq_left",  64'(mq.size()),  64'd0);
        chk("r0q_left", 64'(r0q.size()), 64'd0);
        chk("r1q_left", 64'(r1q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
